lcd_panel_responder: RTL and testbench
======================================

Name: lcd_panel_responder

Overview:
- Synthesizable responder for the KS0108-style two-half graphic LCD bus that the LCD controllers drive. Sits on the other end of that bus.
- Decodes commands, maintains two 64x64 display RAMs (8 pages x 64 columns x 8 bits each), and answers status and data reads.
- Exposes a pixel read port so a scan-out or checker block can fetch display contents.
- Used as an on-chip mirror of the panel and as the bus model in controller benches.

Parameters:
BUSY_CYCLES, 2, clk cycles busy is held after each accepted bus operation (1..15).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
lcd_d  in  8  bus data from controller
lcd_rst  in  1  panel reset, active low (level)
lcd_cs1  in  1  selects left half (cols 0-63), active high
lcd_cs2  in  1  selects right half, active high
lcd_en  in  1  strobe; operation executes on falling edge
lcd_wr  in  1  0 = write, 1 = read
lcd_di  in  1  0 = command/status, 1 = data
lcd_q  out  8  read data / status
lcd_q_oe  out  1  lcd_q valid (read cycle in progress)
busy  out  1  panel busy flag
disp_on  out  2  display-on flag per half (bit0 = cs1)
start_line1  out  6  start line, left half
start_line2  out  6  start line, right half
err_busy  out  1  sticky: an operation arrived while busy
pix_half  in  1  pixel port half select
pix_page  in  3  pixel port page
pix_col  in  6  pixel port column
pix_data  out  8  byte at {pix_half,pix_page,pix_col}, 1-cycle latency

Behaviour:
- Reset (reset=0, async): lcd_q=0, lcd_q_oe=0, busy=0, disp_on=00, start lines=0, err_busy=0, pix_data=0, per-half y=0 and page=0, en_d=0. RAM contents are not cleared.
- lcd_rst=0 (synchronous, level): same register clears as reset except err_busy is kept; status bit4=1. Strobes are ignored while lcd_rst=0.
- Edge detect: en_d <= lcd_en. Falling edge = en_d & ~lcd_en. lcd_d, lcd_di, lcd_wr and cs are sampled in that same cycle.
- Falling edge with neither cs set: no effect, busy not set.
- Falling edge while busy=1: operation ignored, err_busy <= 1.
- Accepted operation: busy=1 for exactly BUSY_CYCLES cycles starting the next cycle.
- Commands (di=0, wr=0), applied to each selected half:
  - 0x3E/0x3F: disp_on=0/1.
  - 11xxxxxx: start_line=d[5:0].
  - 01yyyyyy: y=d[5:0].
  - 10111ppp: page=d[2:0].
  - Any other code: ignored, but still sets busy.
- Data write (di=1, wr=0): RAM[half][page][y] <= lcd_d for each selected half, then y <= y+1 mod 64 (63 wraps to 0). Page never auto-increments.
- Both cs set: both halves are written and incremented independently at their own addresses.
- Reads (wr=1), while lcd_en=1: lcd_q_oe=1, lcd_q registered one cycle after lcd_en rises. lcd_q_oe=0 the cycle after lcd_en falls.
  - Status (di=0): {busy,1'b0,~disp_on[h],~lcd_rst,4'b0}, where h = cs1 ? left : right.
  - Data (di=1): RAM[h][page][y] of the selected half. No dummy read is required. y of that half increments on the falling edge.
  - Reads set busy and are subject to the busy rule, but status reads never set busy and are always accepted.
- pix_data: registered read of the second RAM port, valid one cycle after address. A same-cycle write to that address returns the old byte.
- Simultaneous lcd_rst falling and strobe edge: reset wins, operation dropped.
- reset mid-busy: busy clears immediately.

Test Plan:
1. reset, then cs=11 di=0 d=0x3F strobe -> disp_on=11, busy high for 2 cycles, err_busy=0.
2. cs=01: d=0xB8|3 (page 3), then 0x40|62, then data 0xA5, 0x5A, 0xFF -> pix{0,3,62}=A5, {0,3,63}=5A, {0,3,0}=FF (wrap). Right half unchanged.
3. cs=11, page 0, y=0, data 0x81 -> pix{0,0,0}=81 and pix{1,0,0}=81. Both halves' y=1.
4. Strobe again 1 cycle after an accepted write -> write ignored, err_busy=1 and stays 1 until reset.
5. cs=10 d=0xC5 -> start_line2=5, start_line1 unchanged. Then status read with disp_on2=0 -> lcd_q=0x20, lcd_q_oe during en only. lcd_rst=0 -> status 0x30, disp_on=00, start lines 0.
6. Write 0x3C at {1,2,10}, set y=10, data read -> lcd_q=0x3C, y advances to 11. Assert reset mid-busy -> busy=0 next sample, RAM byte retained.

Source files
------------

// File: rtl/lcd_panel_responder.sv
// rtl/lcd_panel_responder.sv - KS0108-style two-half LCD bus responder with display RAM mirror
// Decodes strobed commands/data, answers status and data reads, exposes a pixel read port.
module lcd_panel_responder #(
  parameter int BUSY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_d,
  input  logic       lcd_rst,
  input  logic       lcd_cs1,
  input  logic       lcd_cs2,
  input  logic       lcd_en,
  input  logic       lcd_wr,
  input  logic       lcd_di,
  output logic [7:0] lcd_q,
  output logic       lcd_q_oe,
  output logic       busy,
  output logic [1:0] disp_on,
  output logic [5:0] start_line1,
  output logic [5:0] start_line2,
  output logic       err_busy,
  input  logic       pix_half,
  input  logic [2:0] pix_page,
  input  logic [5:0] pix_col,
  output logic [7:0] pix_data
);

  localparam logic [3:0] LP_BUSY = 4'(BUSY_CYCLES);

  logic [7:0] r_ram_l [512];
  logic [7:0] r_ram_r [512];

  logic       r_en_d;
  logic [3:0] r_busy_cnt;
  logic [5:0] r_y [2];
  logic [2:0] r_page [2];
  logic [5:0] r_start [2];
  logic [1:0] r_disp_on;
  logic       r_err;
  logic [7:0] r_q;
  logic       r_q_oe;
  logic [7:0] r_pix;

  logic       w_fall;
  logic [1:0] w_sel;
  logic       w_busy;
  logic       w_op;
  logic       w_accept;
  logic       w_cmd;
  logic       w_wdata;
  logic       w_rdata;
  logic       w_h;
  logic       w_rd_act;
  logic [1:0] w_adv;
  logic [8:0] w_addr_l;
  logic [8:0] w_addr_r;
  logic [7:0] w_rd_byte;
  logic [7:0] w_status;

  assign w_fall   = r_en_d & ~lcd_en;
  assign w_sel    = {lcd_cs2, lcd_cs1};
  assign w_busy   = (r_busy_cnt != 4'd0);
  // Status reads never take part in the busy handshake.
  assign w_op     = w_fall & lcd_rst & (|w_sel) & ~(lcd_wr & ~lcd_di);
  assign w_accept = w_op & ~w_busy;
  assign w_cmd    = w_accept & ~lcd_wr & ~lcd_di;
  assign w_wdata  = w_accept & ~lcd_wr &  lcd_di;
  assign w_rdata  = w_accept &  lcd_wr &  lcd_di;
  assign w_h      = ~lcd_cs1;
  assign w_rd_act = lcd_en & lcd_wr & (|w_sel);
  assign w_adv    = w_wdata ? w_sel : (w_rdata ? (lcd_cs1 ? 2'b01 : 2'b10) : 2'b00);

  assign w_addr_l  = {r_page[0], r_y[0]};
  assign w_addr_r  = {r_page[1], r_y[1]};
  assign w_rd_byte = w_h ? r_ram_r[w_addr_r] : r_ram_l[w_addr_l];
  assign w_status  = {w_busy, 1'b0, ~r_disp_on[w_h], ~lcd_rst, 4'b0000};

  always_ff @(posedge clk) begin
    if (w_wdata && lcd_cs1) r_ram_l[w_addr_l] <= lcd_d;
    if (w_wdata && lcd_cs2) r_ram_r[w_addr_r] <= lcd_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_d     <= 1'b0;
      r_busy_cnt <= 4'd0;
      r_disp_on  <= 2'b00;
      r_err      <= 1'b0;
      r_q        <= 8'h00;
      r_q_oe     <= 1'b0;
      r_pix      <= 8'h00;
      for (int h = 0; h < 2; h++) begin
        r_y[h]     <= 6'd0;
        r_page[h]  <= 3'd0;
        r_start[h] <= 6'd0;
      end
    end else begin
      // The read path stays live under panel reset so status can report it.
      r_q_oe <= w_rd_act;
      r_q    <= w_rd_act ? (lcd_di ? w_rd_byte : w_status) : 8'h00;
      if (!lcd_rst) begin
        r_en_d     <= 1'b0;
        r_busy_cnt <= 4'd0;
        r_disp_on  <= 2'b00;
        r_pix      <= 8'h00;
        for (int h = 0; h < 2; h++) begin
          r_y[h]     <= 6'd0;
          r_page[h]  <= 3'd0;
          r_start[h] <= 6'd0;
        end
      end else begin
        r_en_d <= lcd_en;
        r_pix  <= pix_half ? r_ram_r[{pix_page, pix_col}] : r_ram_l[{pix_page, pix_col}];
        if (w_accept)    r_busy_cnt <= LP_BUSY;
        else if (w_busy) r_busy_cnt <= r_busy_cnt - 4'd1;
        if (w_op && w_busy) r_err <= 1'b1;
        for (int h = 0; h < 2; h++) begin
          if (w_cmd && w_sel[h]) begin
            casez (lcd_d)
              8'h3E:       r_disp_on[h] <= 1'b0;
              8'h3F:       r_disp_on[h] <= 1'b1;
              8'b11??????: r_start[h]   <= lcd_d[5:0];
              8'b01??????: r_y[h]       <= lcd_d[5:0];
              8'b10111???: r_page[h]    <= lcd_d[2:0];
              default:     ;
            endcase
          end
          if (w_adv[h]) r_y[h] <= r_y[h] + 6'd1;
        end
      end
    end
  end

  assign lcd_q       = r_q;
  assign lcd_q_oe    = r_q_oe;
  assign busy        = w_busy;
  assign disp_on     = r_disp_on;
  assign start_line1 = r_start[0];
  assign start_line2 = r_start[1];
  assign err_busy    = r_err;
  assign pix_data    = r_pix;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// tb/tb_lcd_panel_responder.sv - randomized bench for lcd_panel_responder against a panel model
// The model keeps RAM/registers as arrays and derives busy from the time of the last accepted op.
module tb_lcd_panel_responder;
  localparam int B = 2;
  localparam int PER = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lcd_d;
  logic       lcd_rst, lcd_cs1, lcd_cs2, lcd_en, lcd_wr, lcd_di;
  logic [7:0] lcd_q;
  logic       lcd_q_oe, busy, err_busy;
  logic [1:0] disp_on;
  logic [5:0] start_line1, start_line2;
  logic       pix_half;
  logic [2:0] pix_page;
  logic [5:0] pix_col;
  logic [7:0] pix_data;

  always #(PER/2) clk = ~clk;

  lcd_panel_responder #(.BUSY_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .lcd_d(lcd_d), .lcd_rst(lcd_rst),
    .lcd_cs1(lcd_cs1), .lcd_cs2(lcd_cs2), .lcd_en(lcd_en), .lcd_wr(lcd_wr),
    .lcd_di(lcd_di), .lcd_q(lcd_q), .lcd_q_oe(lcd_q_oe), .busy(busy),
    .disp_on(disp_on), .start_line1(start_line1), .start_line2(start_line2),
    .err_busy(err_busy), .pix_half(pix_half), .pix_page(pix_page),
    .pix_col(pix_col), .pix_data(pix_data)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] m_mem [2][8][64];
  int         m_y [2];
  int         m_page [2];
  int         m_start [2];
  bit         m_disp [2];
  bit         m_err;
  longint     t_acc;
  logic [7:0] last_q;

  function automatic bit busy_at(input longint t);
    return (t > t_acc) && (t <= t_acc + B * PER);
  endfunction

  function automatic void model_clear(input bit keep_err);
    for (int h = 0; h < 2; h++) begin
      m_y[h] = 0; m_page[h] = 0; m_start[h] = 0; m_disp[h] = 1'b0;
    end
    t_acc = -1000;
    if (!keep_err) m_err = 1'b0;
  endfunction

  function automatic logic [7:0] exp_read(input logic [1:0] cs, input bit di, input longint t);
    int h;
    h = cs[0] ? 0 : 1;
    if (di) return m_mem[h][m_page[h]][m_y[h]];
    return {busy_at(t), 1'b0, ~m_disp[h], ~lcd_rst, 4'b0000};
  endfunction

  function automatic void model_fall(input logic [1:0] cs, input bit di, input bit wr,
                                     input logic [7:0] d, input logic rst_lv, input longint t);
    int h;
    if (cs == 2'b00 || !rst_lv) return;
    if (wr && !di) return;
    if (busy_at(t)) begin
      m_err = 1'b1;
      return;
    end
    t_acc = t;
    if (wr) begin
      h = cs[0] ? 0 : 1;
      m_y[h] = (m_y[h] + 1) % 64;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (cs[k]) begin
        if (di) begin
          m_mem[k][m_page[k]][m_y[k]] = d;
          m_y[k] = (m_y[k] + 1) % 64;
        end else if (d == 8'h3E) m_disp[k] = 1'b0;
        else if (d == 8'h3F)     m_disp[k] = 1'b1;
        else if (d[7:6] == 2'b11) m_start[k] = int'(d[5:0]);
        else if (d[7:6] == 2'b01) m_y[k] = int'(d[5:0]);
        else if (d[7:3] == 5'b10111) m_page[k] = int'(d[2:0]);
      end
    end
  endfunction

  task automatic bus_op(input logic [1:0] cs, input bit di, input bit wr,
                        input logic [7:0] d, input int hold, input bit b2b);
    longint t;
    logic [7:0] exp_q;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    {lcd_cs2, lcd_cs1} = cs;
    lcd_di = di; lcd_wr = wr; lcd_d = d; lcd_en = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      t = $time;
      exp_q = (wr && cs != 2'b00) ? exp_read(cs, di, t) : 8'h00;
      @(negedge clk);
      if (wr) begin
        check_eq("q_oe", {31'd0, lcd_q_oe}, {31'd0, cs != 2'b00});
        check_eq("q", {24'd0, lcd_q}, {24'd0, exp_q});
        last_q = lcd_q;
      end
    end
    lcd_en = 1'b0;
    @(posedge clk);
    t = $time;
    model_fall(cs, di, wr, d, lcd_rst, t);
    @(negedge clk);
    check_eq("q_oe_off", {31'd0, lcd_q_oe}, 32'd0);
    check_eq("busy", {31'd0, busy}, {31'd0, busy_at($time + PER/2)});
    check_eq("err", {31'd0, err_busy}, {31'd0, m_err});
  endtask

  task automatic check_pix(input logic h, input logic [2:0] pg, input logic [5:0] col);
    @(posedge clk); #1;
    pix_half = h; pix_page = pg; pix_col = col;
    @(posedge clk);
    @(negedge clk);
    check_eq("pix", {24'd0, pix_data}, {24'd0, m_mem[h][pg][col]});
  endtask

  task automatic check_regs();
    check_eq("disp_on", {30'd0, disp_on}, {30'd0, m_disp[1], m_disp[0]});
    check_eq("start1", {26'd0, start_line1}, 32'(m_start[0]));
    check_eq("start2", {26'd0, start_line2}, 32'(m_start[1]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; lcd_rst = 1'b1; lcd_en = 1'b0; lcd_cs1 = 1'b0; lcd_cs2 = 1'b0;
    lcd_wr = 1'b0; lcd_di = 1'b0; lcd_d = 8'h00;
    pix_half = 1'b0; pix_page = 3'd0; pix_col = 6'd0;
    last_q = 8'h00; m_err = 1'b0;
    model_clear(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_q", {24'd0, lcd_q}, 32'd0);
    check_eq("rst_oe", {31'd0, lcd_q_oe}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err_busy}, 32'd0);
    check_eq("rst_pix", {24'd0, pix_data}, 32'd0);
    check_regs();
    reset = 1'b1;

    // Display on for both halves; busy lasts B cycles.
    bus_op(2'b11, 1'b0, 1'b0, 8'h3F, 1, 1'b0);
    check_eq("t1_disp", {30'd0, disp_on}, 32'd3);
    @(negedge clk); check_eq("t1_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk); check_eq("t1_busy3", {31'd0, busy}, 32'd0);
    check_eq("t1_err", {31'd0, err_busy}, 32'd0);

    // Fill both RAMs so every address has a known model value.
    for (int pg = 0; pg < 8; pg++) begin
      bus_op(2'b11, 1'b0, 1'b0, 8'hB8 | 8'(pg), 1, 1'b0);
      bus_op(2'b11, 1'b0, 1'b0, 8'h40, 1, 1'b0);
      for (int c = 0; c < 64; c++) bus_op(2'b11, 1'b1, 1'b0, 8'($urandom), 1, 1'b0);
    end

    // Left half column wrap on page 3.
    bus_op(2'b01, 1'b0, 1'b0, 8'hBB, 1, 1'b0);
    bus_op(2'b01, 1'b0, 1'b0, 8'h40 | 8'd62, 1, 1'b0);
    bus_op(2'b01, 1'b1, 1'b0, 8'hA5, 1, 1'b0);
    bus_op(2'b01, 1'b1, 1'b0, 8'h5A, 1, 1'b0);
    bus_op(2'b01, 1'b1, 1'b0, 8'hFF, 1, 1'b0);
    check_pix(1'b0, 3'd3, 6'd62); check_eq("t2_a5", {24'd0, pix_data}, 32'hA5);
    check_pix(1'b0, 3'd3, 6'd63); check_eq("t2_5a", {24'd0, pix_data}, 32'h5A);
    check_pix(1'b0, 3'd3, 6'd0);  check_eq("t2_ff", {24'd0, pix_data}, 32'hFF);
    check_pix(1'b1, 3'd3, 6'd62);
    check_pix(1'b1, 3'd3, 6'd63);

    // Dual-half write, then each half reads from its own y=1.
    bus_op(2'b11, 1'b0, 1'b0, 8'hB8, 1, 1'b0);
    bus_op(2'b11, 1'b0, 1'b0, 8'h40, 1, 1'b0);
    bus_op(2'b11, 1'b1, 1'b0, 8'h81, 1, 1'b0);
    check_pix(1'b0, 3'd0, 6'd0); check_eq("t3_l", {24'd0, pix_data}, 32'h81);
    check_pix(1'b1, 3'd0, 6'd0); check_eq("t3_r", {24'd0, pix_data}, 32'h81);
    bus_op(2'b01, 1'b1, 1'b1, 8'h00, 1, 1'b0);
    bus_op(2'b10, 1'b1, 1'b1, 8'h00, 2, 1'b0);

    // Start line on right half, status read, then panel reset.
    bus_op(2'b10, 1'b0, 1'b0, 8'hC5, 1, 1'b0);
    check_eq("t5_sl2", {26'd0, start_line2}, 32'd5);
    check_regs();
    bus_op(2'b10, 1'b0, 1'b0, 8'h3E, 1, 1'b0);
    bus_op(2'b10, 1'b0, 1'b1, 8'h00, 2, 1'b0);
    check_eq("t5_stat", {24'd0, last_q}, 32'h20);
    @(posedge clk); #1 lcd_rst = 1'b0;
    repeat (2) @(posedge clk);
    model_clear(1'b1);
    bus_op(2'b01, 1'b0, 1'b1, 8'h00, 1, 1'b0);
    check_eq("t5_stat_rst", {24'd0, last_q}, 32'h30);
    check_regs();
    @(posedge clk); #1 lcd_rst = 1'b1;

    // Panel reset landing on the strobe's falling edge drops the write.
    @(posedge clk); #1;
    lcd_cs1 = 1'b1; lcd_cs2 = 1'b0; lcd_di = 1'b1; lcd_wr = 1'b0; lcd_d = 8'h77; lcd_en = 1'b1;
    @(posedge clk); #1;
    lcd_en = 1'b0; lcd_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 lcd_rst = 1'b1;
    model_clear(1'b1);
    check_pix(1'b0, 3'd0, 6'd0);
    check_regs();

    for (int n = 0; n < 300; n++) begin
      logic [1:0] cs;
      logic [7:0] d;
      int         hold;
      bit         b2b;
      cs   = 2'($urandom_range(3, 0));
      hold = $urandom_range(3, 1);
      b2b  = ($urandom_range(7, 0) == 0);
      case ($urandom_range(4, 0))
        0: begin
          case ($urandom_range(5, 0))
            0: d = 8'h3E;
            1: d = 8'h3F;
            2: d = 8'hC0 | 8'($urandom_range(63, 0));
            3: d = 8'h40 | 8'($urandom_range(63, 0));
            4: d = 8'hB8 | 8'($urandom_range(7, 0));
            default: d = 8'($urandom);
          endcase
          bus_op(cs, 1'b0, 1'b0, d, hold, b2b);
        end
        1, 2: bus_op(cs, 1'b1, 1'b0, 8'($urandom), hold, b2b);
        3: bus_op(cs, 1'b1, 1'b1, 8'h00, hold, b2b);
        default: bus_op(cs, 1'b0, 1'b1, 8'h00, hold, b2b);
      endcase
      if (n % 10 == 9) begin
        check_pix(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 6'($urandom_range(63, 0)));
        check_regs();
      end
    end

    // A strobe one cycle after an accepted write is rejected and flagged.
    bus_op(2'b01, 1'b0, 1'b0, 8'hB9, 1, 1'b0);
    bus_op(2'b01, 1'b0, 1'b0, 8'h45, 1, 1'b0);
    bus_op(2'b01, 1'b1, 1'b0, 8'h11, 1, 1'b0);
    bus_op(2'b01, 1'b1, 1'b0, 8'h22, 1, 1'b1);
    check_eq("t4_err", {31'd0, err_busy}, 32'd1);
    check_pix(1'b0, 3'd1, 6'd6);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("t4_err_sticky", {31'd0, err_busy}, 32'd1);

    // Write then read back through the bus on the right half.
    bus_op(2'b10, 1'b0, 1'b0, 8'hBA, 1, 1'b0);
    bus_op(2'b10, 1'b0, 1'b0, 8'h4A, 1, 1'b0);
    bus_op(2'b10, 1'b1, 1'b0, 8'h3C, 1, 1'b0);
    bus_op(2'b10, 1'b0, 1'b0, 8'h4A, 1, 1'b0);
    bus_op(2'b10, 1'b1, 1'b1, 8'h00, 1, 1'b0);
    check_eq("t6_q", {24'd0, last_q}, 32'h3C);
    check_eq("t6_y", 32'(m_y[1]), 32'd11);
    bus_op(2'b10, 1'b1, 1'b1, 8'h00, 1, 1'b0);

    // Asynchronous reset in the middle of a busy window.
    bus_op(2'b10, 1'b0, 1'b0, 8'h3F, 1, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("t6_busy_rst", {31'd0, busy}, 32'd0);
    check_eq("t6_err_rst", {31'd0, err_busy}, 32'd0);
    model_clear(1'b0);
    @(negedge clk);
    reset = 1'b1;
    check_regs();
    check_pix(1'b1, 3'd2, 6'd10);
    check_eq("t6_ram", {24'd0, pix_data}, 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
